// File: rtl/answer_judge.sv
// answer_judge: quiz round sequencer. Arms a round when a target arrives,
// takes the first rising-edge buzz from an unlocked player, judges the
// registered answer, keeps four saturating scores and declares a winner.
module answer_judge #(
  parameter int WIN_SCORE     = 10,
  parameter int ROUND_TIMEOUT = 500000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gameHasStarted,
  input  logic        playerInputFlag,
  input  logic [1:0]  firstPlayerFlag,
  input  logic [7:0]  switchInput,
  input  logic        allButtons,
  input  logic [7:0]  targetValue,
  input  logic        targetValid,
  output logic        newTarget,
  output logic        correct,
  output logic        wrong,
  output logic [31:0] scores,
  output logic [3:0]  lockMask,
  output logic [1:0]  winner,
  output logic        gameOver,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_TARGET = 3'd1,
    ARMED       = 3'd2,
    SAMPLE      = 3'd3,
    JUDGE       = 3'd4,
    DONE        = 3'd5
  } state_t;

  localparam int             CW       = 29;
  localparam logic [CW-1:0]  CNT_LAST = CW'(ROUND_TIMEOUT - 1);
  localparam logic [7:0]     WIN      = 8'(WIN_SCORE);

  state_t          state_q, state_d;
  logic [7:0]      target_q, target_d;
  logic [7:0]      answer_q, answer_d;
  logic [1:0]      player_q, player_d;
  logic [3:0][7:0] scores_q, scores_d;
  logic [3:0]      lock_q, lock_d;
  logic [1:0]      winner_q, winner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            flag_q;
  logic            nt_q, nt_d;

  logic            buzz;
  logic [7:0]      new_score;
  logic [3:0]      new_lock;

  assign buzz      = playerInputFlag & ~flag_q;
  assign new_score = (scores_q[player_q] == 8'hFF) ? 8'hFF : scores_q[player_q] + 8'd1;
  assign new_lock  = lock_q | (4'b0001 << player_q);

  // Next-state / datapath. newTarget is registered so it rises together with
  // the new WAIT_TARGET state; correct/wrong are decoded in JUDGE, so the
  // three pulses live in different states and can never overlap. correct and
  // wrong are masked by rst so a reset edge during JUDGE emits no pulse.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    answer_d = answer_q;
    player_d = player_q;
    scores_d = scores_q;
    lock_d   = lock_q;
    winner_d = winner_q;
    cnt_d    = cnt_q;
    nt_d     = 1'b0;
    correct  = 1'b0;
    wrong    = 1'b0;
    if (allButtons && state_q != IDLE) begin
      state_d  = IDLE;
      scores_d = '0;
      lock_d   = '0;
      cnt_d    = '0;
      winner_d = '0;
    end else begin
      case (state_q)
        IDLE: if (gameHasStarted) begin
          state_d = WAIT_TARGET;
          nt_d    = 1'b1;
        end
        WAIT_TARGET: if (targetValid) begin
          target_d = targetValue;
          lock_d   = '0;
          cnt_d    = '0;
          state_d  = ARMED;
        end
        ARMED: begin
          if (cnt_q == CNT_LAST) begin
            state_d = WAIT_TARGET;
            nt_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
            if (buzz && !lock_q[firstPlayerFlag]) state_d = SAMPLE;
          end
        end
        SAMPLE: begin
          player_d = firstPlayerFlag;
          answer_d = switchInput;
          state_d  = JUDGE;
        end
        JUDGE: begin
          if (answer_q == target_q) begin
            correct            = rst;
            scores_d[player_q] = new_score;
            if (new_score >= WIN) begin
              winner_d = player_q;
              state_d  = DONE;
            end else begin
              state_d = WAIT_TARGET;
              nt_d    = 1'b1;
            end
          end else begin
            wrong  = rst;
            lock_d = new_lock;
            if (new_lock == 4'hF) begin
              state_d = WAIT_TARGET;
              nt_d    = 1'b1;
            end else begin
              state_d = ARMED;
            end
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      target_q <= '0;
      answer_q <= '0;
      player_q <= '0;
      scores_q <= '0;
      lock_q   <= '0;
      winner_q <= '0;
      cnt_q    <= '0;
      flag_q   <= 1'b0;
      nt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      answer_q <= answer_d;
      player_q <= player_d;
      scores_q <= scores_d;
      lock_q   <= lock_d;
      winner_q <= winner_d;
      cnt_q    <= cnt_d;
      flag_q   <= playerInputFlag;
      nt_q     <= nt_d;
    end
  end

  assign newTarget = nt_q;
  assign scores    = scores_q;
  assign lockMask  = lock_q;
  assign winner    = winner_q;
  assign gameOver  = (state_q == DONE);
  assign state     = state_q;

endmodule

// File: tb/tb_answer_judge.sv
// Bench for answer_judge: a table of per-cycle vectors (inputs plus outputs
// expected after the edge) run through a scoreboard queue, then hand-written
// sequences for reset-during-JUDGE and abort with nonzero scores.
module tb_answer_judge;

  localparam logic [2:0] S_IDLE = 3'd0, S_WT = 3'd1, S_AR = 3'd2,
                         S_SA = 3'd3, S_JU = 3'd4, S_DN = 3'd5;

  logic        clk = 1'b0;
  logic        rst, gameHasStarted, playerInputFlag, allButtons, targetValid;
  logic [1:0]  firstPlayerFlag;
  logic [7:0]  switchInput, targetValue;
  logic        newTarget, correct, wrong, gameOver;
  logic [31:0] scores;
  logic [3:0]  lockMask;
  logic [1:0]  winner;
  logic [2:0]  state;

  always #5 clk = ~clk;

  answer_judge #(.WIN_SCORE(2), .ROUND_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .gameHasStarted(gameHasStarted),
    .playerInputFlag(playerInputFlag), .firstPlayerFlag(firstPlayerFlag),
    .switchInput(switchInput), .allButtons(allButtons),
    .targetValue(targetValue), .targetValid(targetValid),
    .newTarget(newTarget), .correct(correct), .wrong(wrong),
    .scores(scores), .lockMask(lockMask), .winner(winner),
    .gameOver(gameOver), .state(state)
  );

  typedef struct {
    logic r, gs, pf; logic [1:0] fp; logic [7:0] sw; logic ab, tv; logic [7:0] tval;
  } in_t;
  typedef struct {
    logic [2:0] st; logic nt, c, w; logic [3:0] lm; logic [31:0] sc; logic go; logic [1:0] wn;
  } exp_t;
  typedef struct { in_t i; exp_t e; } vec_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   vidx   = 0;

  task automatic add(input logic r, gs, pf, input logic [1:0] fp, input logic [7:0] sw,
                     input logic ab, tv, input logic [7:0] tval,
                     input logic [2:0] st, input logic nt, c, w, input logic [3:0] lm,
                     input logic [31:0] sc, input logic go, input logic [1:0] wn);
    vec_t v;
    v.i.r = r; v.i.gs = gs; v.i.pf = pf; v.i.fp = fp; v.i.sw = sw;
    v.i.ab = ab; v.i.tv = tv; v.i.tval = tval;
    v.e.st = st; v.e.nt = nt; v.e.c = c; v.e.w = w; v.e.lm = lm;
    v.e.sc = sc; v.e.go = go; v.e.wn = wn;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input in_t i);
    rst = i.r; gameHasStarted = i.gs; playerInputFlag = i.pf; firstPlayerFlag = i.fp;
    switchInput = i.sw; allButtons = i.ab; targetValid = i.tv; targetValue = i.tval;
  endtask

  // Drive one vector, push its expectation, clock, then pop and compare.
  task automatic apply(input vec_t v);
    exp_t e;
    string p;
    drive(v.i);
    sb.push_back(v.e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    p = $sformatf("v%0d", vidx);
    chk({p, ".state"},     32'(state),     32'(e.st));
    chk({p, ".newTarget"}, 32'(newTarget), 32'(e.nt));
    chk({p, ".correct"},   32'(correct),   32'(e.c));
    chk({p, ".wrong"},     32'(wrong),     32'(e.w));
    chk({p, ".lockMask"},  32'(lockMask),  32'(e.lm));
    chk({p, ".scores"},    scores,         e.sc);
    chk({p, ".gameOver"},  32'(gameOver),  32'(e.go));
    if (e.go) chk({p, ".winner"}, 32'(winner), 32'(e.wn));
    vidx++;
  endtask

  localparam logic [31:0] S1 = 32'h0001_0000;

  initial begin
    // reset, with a button already held
    add(0,0,0,0,8'h00,0,0,8'h00, S_IDLE,0,0,0,4'h0,0,0,0);
    add(0,0,1,0,8'h00,0,0,8'h00, S_IDLE,0,0,0,4'h0,0,0,0);
    // start, target 2A, player 2 answers 2A
    add(1,1,1,0,8'h00,0,0,8'h00, S_WT,1,0,0,4'h0,0,0,0);
    add(1,0,0,0,8'h00,0,0,8'h00, S_WT,0,0,0,4'h0,0,0,0);
    add(1,0,0,0,8'h00,0,1,8'h2A, S_AR,0,0,0,4'h0,0,0,0);
    add(1,0,1,2,8'h2A,0,0,8'h00, S_SA,0,0,0,4'h0,0,0,0);
    add(1,0,1,2,8'h2A,0,0,8'h00, S_JU,0,1,0,4'h0,0,0,0);
    add(1,0,0,0,8'h00,0,0,8'h00, S_WT,1,0,0,4'h0,S1,0,0);
    // target 05, player 0 wrong, then locked re-buzz ignored
    add(1,0,0,0,8'h00,0,1,8'h05, S_AR,0,0,0,4'h0,S1,0,0);
    add(1,0,1,0,8'h04,0,0,8'h00, S_SA,0,0,0,4'h0,S1,0,0);
    add(1,0,1,0,8'h04,0,0,8'h00, S_JU,0,0,1,4'h0,S1,0,0);
    add(1,0,0,0,8'h00,0,0,8'h00, S_AR,0,0,0,4'h1,S1,0,0);
    add(1,0,1,0,8'h04,0,0,8'h00, S_AR,0,0,0,4'h1,S1,0,0);
    add(1,0,0,0,8'h00,0,0,8'h00, S_AR,0,0,0,4'h1,S1,0,0);
    // players 1..3 also wrong -> round void
    for (int p = 1; p < 4; p++) begin
      add(1,0,1,2'(p),8'h00,0,0,8'h00, S_SA,0,0,0,4'((1 << p) - 1),S1,0,0);
      add(1,0,1,2'(p),8'h00,0,0,8'h00, S_JU,0,0,1,4'((1 << p) - 1),S1,0,0);
      if (p < 3) add(1,0,0,0,8'h00,0,0,8'h00, S_AR,0,0,0,4'((1 << (p + 1)) - 1),S1,0,0);
      else       add(1,0,0,0,8'h00,0,0,8'h00, S_WT,1,0,0,4'hF,S1,0,0);
    end
    // player 1 correct twice -> wins
    add(1,0,0,0,8'h00,0,1,8'h11, S_AR,0,0,0,4'h0,S1,0,0);
    add(1,0,1,1,8'h11,0,0,8'h00, S_SA,0,0,0,4'h0,S1,0,0);
    add(1,0,1,1,8'h11,0,0,8'h00, S_JU,0,1,0,4'h0,S1,0,0);
    add(1,0,0,0,8'h00,0,0,8'h00, S_WT,1,0,0,4'h0,32'h0001_0100,0,0);
    add(1,0,0,0,8'h00,0,1,8'h22, S_AR,0,0,0,4'h0,32'h0001_0100,0,0);
    add(1,0,1,1,8'h22,0,0,8'h00, S_SA,0,0,0,4'h0,32'h0001_0100,0,0);
    add(1,0,1,1,8'h22,0,0,8'h00, S_JU,0,1,0,4'h0,32'h0001_0100,0,0);
    add(1,0,0,0,8'h00,0,0,8'h00, S_DN,0,0,0,4'h0,32'h0001_0200,1,1);
    add(1,0,0,0,8'h00,0,0,8'h00, S_DN,0,0,0,4'h0,32'h0001_0200,1,1);
    add(1,0,0,0,8'h00,1,0,8'h00, S_IDLE,0,0,0,4'h0,0,0,0);
    add(1,0,0,0,8'h00,0,0,8'h00, S_IDLE,0,0,0,4'h0,0,0,0);
    // timeout: 8 ARMED cycles, buzz on the expiring cycle ignored
    add(1,1,0,0,8'h00,0,0,8'h00, S_WT,1,0,0,4'h0,0,0,0);
    add(1,0,0,0,8'h00,0,1,8'h00, S_AR,0,0,0,4'h0,0,0,0);
    for (int k = 0; k < 7; k++) add(1,0,0,0,8'h00,0,0,8'h00, S_AR,0,0,0,4'h0,0,0,0);
    add(1,0,1,0,8'h00,0,0,8'h00, S_WT,1,0,0,4'h0,0,0,0);
    add(1,0,0,0,8'h00,0,0,8'h00, S_WT,0,0,0,4'h0,0,0,0);

    foreach (vecs[n]) apply(vecs[n]);
    vecs.delete();

    // reset asserted while JUDGE holds a correct answer
    add(1,0,0,0,8'h00,0,1,8'h44, S_AR,0,0,0,4'h0,0,0,0);
    add(1,0,1,3,8'h44,0,0,8'h00, S_SA,0,0,0,4'h0,0,0,0);
    add(1,0,1,3,8'h44,0,0,8'h00, S_JU,0,1,0,4'h0,0,0,0);
    foreach (vecs[n]) apply(vecs[n]);
    vecs.delete();
    rst = 1'b0;
    #1;
    chk("judge_rst.correct_pre", 32'(correct), 32'd0);
    add(0,0,1,3,8'h44,0,0,8'h00, S_IDLE,0,0,0,4'h0,0,0,0);
    // score player 3, then abort from ARMED clears it
    add(1,1,0,0,8'h00,0,0,8'h00, S_WT,1,0,0,4'h0,0,0,0);
    add(1,0,0,0,8'h00,0,1,8'h44, S_AR,0,0,0,4'h0,0,0,0);
    add(1,0,1,3,8'h44,0,0,8'h00, S_SA,0,0,0,4'h0,0,0,0);
    add(1,0,1,3,8'h44,0,0,8'h00, S_JU,0,1,0,4'h0,0,0,0);
    add(1,0,0,0,8'h00,0,0,8'h00, S_WT,1,0,0,4'h0,32'h0100_0000,0,0);
    add(1,0,0,0,8'h00,0,1,8'h55, S_AR,0,0,0,4'h0,32'h0100_0000,0,0);
    add(1,0,0,0,8'h00,1,0,8'h00, S_IDLE,0,0,0,4'h0,0,0,0);
    foreach (vecs[n]) apply(vecs[n]);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: got %0d leftover expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
